fmult_accum_seq: RTL and testbench

Sequencer that time-shares a single combinational FMULT instance across the eight predictor products of the ADPCM adaptive predictor (six zero-section and two pole-section terms). It latches the coefficients and float operands on a start request, presents one TC/FL pair per cycle to the shared FMULT, and accumulates the returned products. It then publishes the signal estimates SEZ and SE with a done pulse. It sits between the predictor-state registers and the FMULT datapath.

---
 rtl/fmult_accum_seq.sv | 122 ++++++++++++
 tb/tb_fmult_accum_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmult_accum_seq.sv
// fmult_accum_seq
// Time-shares one combinational FMULT across the eight ADPCM predictor
// products (B1..B6 x DQ1..DQ6, A1 x SR1, A2 x SR2). The operands are latched
// on a start request and presented one pair per cycle. The returned products
// are accumulated, and SEZ/SE are published with a one-cycle done pulse.
//
// Ports:
//   I_CLK          system clock, rising edge
//   I_RESET_N      asynchronous active-low reset
//   I_START        request, sampled only while idle
//   I128_B         B1..B6, A1, A2 (16-bit two's complement, B1 in [15:0])
//   I88_FL         DQ1..DQ6, SR1, SR2 (11-bit float, DQ1 in [10:0])
//   O16_MULT_TC    TC operand to the shared FMULT
//   O11_MULT_FL    float operand to the shared FMULT
//   I16_MULT_PROD  FMULT product, combinational from the two operands
//   O15_SEZ        zero-section estimate, registered
//   O15_SE         full signal estimate, registered
//   O_BUSY         high while products are being sequenced
//   O_DONE         one-cycle pulse when O15_SEZ/O15_SE update
module fmult_accum_seq (
  input  logic         I_CLK,
  input  logic         I_RESET_N,
  input  logic         I_START,
  input  logic [127:0] I128_B,
  input  logic [87:0]  I88_FL,
  output logic [15:0]  O16_MULT_TC,
  output logic [10:0]  O11_MULT_FL,
  input  logic [15:0]  I16_MULT_PROD,
  output logic [14:0]  O15_SEZ,
  output logic [14:0]  O15_SE,
  output logic         O_BUSY,
  output logic         O_DONE
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]   state;
  logic [2:0]   idx;
  logic [15:0]  acc;
  logic [15:0]  sezi;
  logic [127:0] b_reg;
  logic [87:0]  fl_reg;
  logic [14:0]  sez_reg;
  logic [14:0]  se_reg;
  logic         done_reg;

  logic [15:0]  sum;
  logic [6:0]   tc_base;
  logic [6:0]   fl_base;

  // Running sum including the product of the pair currently on the bus.
  // It wraps modulo 2^16 and does not saturate.
  assign sum = acc + I16_MULT_PROD;

  // Bit offsets of the selected operand pair inside the latched buses.
  // The largest offsets (112 and 77) still fit in 7 bits.
  assign tc_base = {idx, 4'b0000};
  assign fl_base = idx * 7'd11;

  // The operand mux feeds the FMULT directly. It is forced to zero while
  // idle so that the shared multiplier sees quiet inputs.
  always_comb begin
    O16_MULT_TC = 16'd0;
    O11_MULT_FL = 11'd0;
    if (state == ST_MUL) begin
      O16_MULT_TC = b_reg[tc_base +: 16];
      O11_MULT_FL = fl_reg[fl_base +: 11];
    end
  end

  assign O_BUSY  = (state == ST_MUL);
  assign O_DONE  = done_reg;
  assign O15_SEZ = sez_reg;
  assign O15_SE  = se_reg;

  // Sequencer. The idle state accepts a start and latches the operands.
  // The MUL state accumulates one product per cycle. The zero-section
  // partial sum is snapshotted after the sixth product. The final product
  // publishes both estimates, halved by dropping bit 0 of the sums.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state    <= ST_IDLE;
      idx      <= 3'd0;
      acc      <= 16'd0;
      sezi     <= 16'd0;
      b_reg    <= 128'd0;
      fl_reg   <= 88'd0;
      sez_reg  <= 15'd0;
      se_reg   <= 15'd0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (I_START) begin
            b_reg  <= I128_B;
            fl_reg <= I88_FL;
            acc    <= 16'd0;
            idx    <= 3'd0;
            state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          acc <= sum;
          idx <= idx + 3'd1;
          if (idx == 3'd5) begin
            sezi <= sum;
          end
          if (idx == 3'd7) begin
            sez_reg  <= sezi[15:1];
            se_reg   <= sum[15:1];
            done_reg <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmult_accum_seq.sv
// tb_fmult_accum_seq
// Self-checking bench for fmult_accum_seq. A behavioural FMULT stub closes
// the product loop. Expected estimates come from summing the stub's products
// over the operand sets that the bench itself supplied.
module tb_fmult_accum_seq;

  logic         I_CLK;
  logic         I_RESET_N;
  logic         I_START;
  logic [127:0] I128_B;
  logic [87:0]  I88_FL;
  logic [15:0]  O16_MULT_TC;
  logic [10:0]  O11_MULT_FL;
  logic [15:0]  I16_MULT_PROD;
  logic [14:0]  O15_SEZ;
  logic [14:0]  O15_SE;
  logic         O_BUSY;
  logic         O_DONE;

  int total = 0;
  int bad   = 0;

  // Stub modes: 0 hashes the operands, 1 returns a constant,
  // 2 returns the constant only for a nonzero TC operand.
  int          stub_mode  = 0;
  logic [15:0] stub_const = 16'd0;

  fmult_accum_seq dut (
    .I_CLK        (I_CLK),
    .I_RESET_N    (I_RESET_N),
    .I_START      (I_START),
    .I128_B       (I128_B),
    .I88_FL       (I88_FL),
    .O16_MULT_TC  (O16_MULT_TC),
    .O11_MULT_FL  (O11_MULT_FL),
    .I16_MULT_PROD(I16_MULT_PROD),
    .O15_SEZ      (O15_SEZ),
    .O15_SE       (O15_SE),
    .O_BUSY       (O_BUSY),
    .O_DONE       (O_DONE)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  function automatic logic [15:0] fmult_stub(input logic [15:0] tc, input logic [10:0] fl,
                                             input int mode, input logic [15:0] cval);
    case (mode)
      1:       return cval;
      2:       return (tc != 16'd0) ? cval : 16'd0;
      default: return (tc + {fl, 5'b00000}) ^ 16'h3C5A;
    endcase
  endfunction

  always_comb I16_MULT_PROD = fmult_stub(O16_MULT_TC, O11_MULT_FL, stub_mode, stub_const);

  // Reference: SEZ is half the sum of the six zero-section products. SE is
  // half the sum of all eight products. All sums are taken modulo 2^16.
  function automatic void model(input logic [127:0] b, input logic [87:0] fl,
                                output logic [14:0] sez, output logic [14:0] se);
    logic [15:0] s6;
    logic [15:0] s8;
    s6 = 16'd0;
    for (int i = 0; i < 6; i++) s6 = s6 + fmult_stub(b[i*16 +: 16], fl[i*11 +: 11], stub_mode, stub_const);
    s8 = s6;
    for (int i = 6; i < 8; i++) s8 = s8 + fmult_stub(b[i*16 +: 16], fl[i*11 +: 11], stub_mode, stub_const);
    sez = s6[15:1];
    se  = s8[15:1];
  endfunction

  function automatic logic [127:0] rand_b();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [87:0] rand_fl();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[87:0];
  endfunction

  // Present a start for one edge, then scramble the buses, which are
  // don't-care once the request has been accepted.
  task automatic do_start(input logic [127:0] b, input logic [87:0] fl);
    I_START = 1'b1;
    I128_B  = b;
    I88_FL  = fl;
    @(posedge I_CLK); #1;
    I_START = 1'b0;
    I128_B  = rand_b();
    I88_FL  = rand_fl();
  endtask

  // Count edges until O_DONE is seen. The result is -1 if the bound expires.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge I_CLK); #1;
      if (O_DONE) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    I_RESET_N = 1'b0;
    I_START   = 1'b0;
    I128_B    = rand_b();
    I88_FL    = rand_fl();
    #23;
    total++;
    if ({O15_SEZ, O15_SE, O_BUSY, O_DONE, O16_MULT_TC, O11_MULT_FL} !== 59'd0) begin
      bad++;
      $display("[TB] FAIL reset_state: got sez=%h se=%h busy=%b done=%b tc=%h fl=%h want all 0",
               O15_SEZ, O15_SE, O_BUSY, O_DONE, O16_MULT_TC, O11_MULT_FL);
    end
    @(posedge I_CLK); #1;
    I_RESET_N = 1'b1;
  endtask

  task automatic test_sequencing();
    logic [127:0] b;
    logic [87:0]  fl;
    logic [15:0]  exp_tc;
    logic [10:0]  exp_fl;
    int           edges;
    stub_mode = 0;
    for (int i = 0; i < 6; i++) b[i*16 +: 16] = 16'h0100 * (i + 1);
    b[111:96]  = 16'h1234;
    b[127:112] = 16'hABCD;
    for (int i = 0; i < 8; i++) fl[i*11 +: 11] = 11'h101 + 11'h013 * i;
    do_start(b, fl);
    for (int k = 0; k < 8; k++) begin
      exp_tc = b[k*16 +: 16];
      exp_fl = fl[k*11 +: 11];
      total++;
      if (O16_MULT_TC !== exp_tc || O11_MULT_FL !== exp_fl || O_BUSY !== 1'b1) begin
        bad++;
        $display("[TB] FAIL seq_pair%0d: got tc=%h fl=%h busy=%b want tc=%h fl=%h busy=1",
                 k, O16_MULT_TC, O11_MULT_FL, O_BUSY, exp_tc, exp_fl);
      end
      if (k < 7) begin
        @(posedge I_CLK); #1;
      end
    end
    wait_done(edges);
    total++;
    if (edges != 1 || O16_MULT_TC !== 16'd0 || O11_MULT_FL !== 11'd0) begin
      bad++;
      $display("[TB] FAIL seq_idle: got edges=%0d tc=%h fl=%h want edges=1 tc=0 fl=0",
               edges, O16_MULT_TC, O11_MULT_FL);
    end
  endtask

  task automatic test_constant_sum(input logic [15:0] cval, input logic [14:0] exp_sez,
                                   input logic [14:0] exp_se, input int mode, input logic [127:0] b);
    int edges;
    stub_mode  = mode;
    stub_const = cval;
    do_start(b, rand_fl());
    wait_done(edges);
    total++;
    if (edges != 8) begin
      bad++;
      $display("[TB] FAIL const_latency(%h): got edges=%0d want 8", cval, edges);
    end
    total++;
    if (O15_SEZ !== exp_sez || O15_SE !== exp_se) begin
      bad++;
      $display("[TB] FAIL const_result(%h): got sez=%h se=%h want sez=%h se=%h",
               cval, O15_SEZ, O15_SE, exp_sez, exp_se);
    end
    @(posedge I_CLK); #1;
    total++;
    if (O_DONE !== 1'b0 || O_BUSY !== 1'b0 || O15_SEZ !== exp_sez) begin
      bad++;
      $display("[TB] FAIL const_pulse(%h): got done=%b busy=%b sez=%h want done=0 busy=0 sez=%h",
               cval, O_DONE, O_BUSY, O15_SEZ, exp_sez);
    end
  endtask

  task automatic test_random();
    logic [127:0] b;
    logic [87:0]  fl;
    logic [14:0]  exp_sez;
    logic [14:0]  exp_se;
    int           edges;
    stub_mode = 0;
    for (int t = 0; t < 6; t++) begin
      b  = rand_b();
      fl = rand_fl();
      model(b, fl, exp_sez, exp_se);
      do_start(b, fl);
      wait_done(edges);
      total++;
      if (edges != 8 || O15_SEZ !== exp_sez || O15_SE !== exp_se) begin
        bad++;
        $display("[TB] FAIL random%0d: got edges=%0d sez=%h se=%h want edges=8 sez=%h se=%h",
                 t, edges, O15_SEZ, O15_SE, exp_sez, exp_se);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] b0;
    logic [127:0] b1;
    logic         exp_busy;
    int           edges;
    stub_mode = 0;
    b0 = rand_b();
    b1 = rand_b();
    I_START = 1'b1;
    I128_B  = b0;
    I88_FL  = rand_fl();
    for (int k = 0; k < 20; k++) begin
      @(posedge I_CLK); #1;
      exp_busy = !(k == 8 || k == 17);
      total++;
      if (O_BUSY !== exp_busy || O_DONE !== !exp_busy) begin
        bad++;
        $display("[TB] FAIL b2b_busy%0d: got busy=%b done=%b want busy=%b done=%b",
                 k, O_BUSY, O_DONE, exp_busy, !exp_busy);
      end
      if (k == 3) begin
        I128_B = b1;
        I88_FL = rand_fl();
      end
      if (k == 4) begin
        total++;
        if (O16_MULT_TC !== b0[79:64]) begin
          bad++;
          $display("[TB] FAIL b2b_hold: got tc=%h want %h", O16_MULT_TC, b0[79:64]);
        end
      end
      if (k == 9) begin
        total++;
        if (O16_MULT_TC !== b1[15:0]) begin
          bad++;
          $display("[TB] FAIL b2b_relatch: got tc=%h want %h", O16_MULT_TC, b1[15:0]);
        end
      end
    end
    I_START = 1'b0;
    wait_done(edges);
    total++;
    if (edges != 7) begin
      bad++;
      $display("[TB] FAIL b2b_drain: got edges=%0d want 7", edges);
    end
  endtask

  task automatic test_reset_midop();
    logic [127:0] b;
    logic [87:0]  fl;
    logic [14:0]  exp_sez;
    logic [14:0]  exp_se;
    int           done_seen;
    int           edges;
    stub_mode = 0;
    b  = rand_b();
    fl = rand_fl();
    do_start(b, fl);
    for (int k = 0; k < 4; k++) begin
      @(posedge I_CLK); #1;
    end
    total++;
    if (O16_MULT_TC !== b[79:64] || O11_MULT_FL !== fl[54:44]) begin
      bad++;
      $display("[TB] FAIL midop_idx4: got tc=%h fl=%h want tc=%h fl=%h",
               O16_MULT_TC, O11_MULT_FL, b[79:64], fl[54:44]);
    end
    #2;
    I_RESET_N = 1'b0;
    #1;
    total++;
    if ({O15_SEZ, O15_SE, O_BUSY, O_DONE, O16_MULT_TC, O11_MULT_FL} !== 59'd0) begin
      bad++;
      $display("[TB] FAIL midop_async: got sez=%h se=%h busy=%b done=%b tc=%h fl=%h want all 0",
               O15_SEZ, O15_SE, O_BUSY, O_DONE, O16_MULT_TC, O11_MULT_FL);
    end
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge I_CLK); #1;
      if (O_DONE) done_seen++;
    end
    I_RESET_N = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge I_CLK); #1;
      if (O_DONE) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      bad++;
      $display("[TB] FAIL midop_nodone: got %0d done pulses want 0", done_seen);
    end
    b  = rand_b();
    fl = rand_fl();
    model(b, fl, exp_sez, exp_se);
    do_start(b, fl);
    wait_done(edges);
    total++;
    if (edges != 8 || O15_SEZ !== exp_sez || O15_SE !== exp_se) begin
      bad++;
      $display("[TB] FAIL midop_restart: got edges=%0d sez=%h se=%h want edges=8 sez=%h se=%h",
               edges, O15_SEZ, O15_SE, exp_sez, exp_se);
    end
  endtask

  initial begin
    logic [127:0] bw;
    for (int i = 0; i < 6; i++) bw[i*16 +: 16] = 16'h0100 * (i + 1);
    bw[127:96] = 32'd0;
    test_reset();
    test_sequencing();
    test_constant_sum(16'h0010, 15'h0030, 15'h0040, 1, rand_b());
    test_constant_sum(16'hFFFE, 15'h7FFA, 15'h7FF8, 1, rand_b());
    test_constant_sum(16'h4000, 15'h4000, 15'h4000, 2, bw);
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
